// File: rtl/lpt_centronics_sequencer.sv
// Centronics parallel-port byte sequencer: 4-deep transmit FIFO feeding a
// SETUP/STROBE/HOLD handshake with BUSY/ACK synchronizers and wait timeouts.
module lpt_centronics_sequencer #(
  parameter int unsigned SETUP_CYC   = 4,
  parameter int unsigned STROBE_CYC  = 4,
  parameter int unsigned HOLD_CYC    = 4,
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       clr_err,
  input  logic       BUSY,
  input  logic       ACK,
  output logic [7:0] data,
  output logic       STROBE,
  output logic       fifo_full,
  output logic       fifo_empty,
  output logic       seq_busy,
  output logic       timeout_err,
  output logic       ovf_err
);

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned PW    = 2;
  localparam int unsigned CW    = 3;
  localparam int unsigned PHW   = 8;
  localparam int unsigned TW    = 16;

  localparam logic [PHW-1:0] SETUP_LD  = PHW'(SETUP_CYC - 1);
  localparam logic [PHW-1:0] STROBE_LD = PHW'(STROBE_CYC - 1);
  localparam logic [PHW-1:0] HOLD_LD   = PHW'(HOLD_CYC - 1);
  localparam logic [TW-1:0]  TMO_LAST  = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_BUSY,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_WAIT_ACK
  } state_t;

  state_t         state, state_nxt;
  logic           busy_m, busy_s;
  logic           ack_m, ack_s, ack_d;
  logic           ack_fall;
  logic [DW-1:0]  mem [DEPTH];
  logic [PW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]  count, count_nxt;
  logic [PHW-1:0] phase_cnt, phase_nxt;
  logic [TW-1:0]  tmo_cnt, tmo_nxt;
  logic           push, pop, tmo_set, ovf_set;

  // BUSY/ACK come straight off the connector; two flops each before use
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_m <= 1'b0;
      busy_s <= 1'b0;
      ack_m  <= 1'b0;
      ack_s  <= 1'b0;
      ack_d  <= 1'b0;
    end else begin
      busy_m <= BUSY;
      busy_s <= busy_m;
      ack_m  <= ACK;
      ack_s  <= ack_m;
      ack_d  <= ack_s;
    end
  end

  assign ack_fall  = ack_d & ~ack_s;
  assign push      = wr_en && (count != CW'(DEPTH));
  assign ovf_set   = wr_en && (count == CW'(DEPTH));
  assign count_nxt = count + CW'(push) - CW'(pop);

  // Next-state, pop request and phase/timeout counter updates
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    phase_nxt = phase_cnt;
    tmo_nxt   = tmo_cnt;
    tmo_set   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (count != '0) begin
          pop       = 1'b1;
          phase_nxt = SETUP_LD;
          tmo_nxt   = '0;
          state_nxt = busy_s ? ST_WAIT_BUSY : ST_SETUP;
        end
      end
      ST_WAIT_BUSY: begin
        tmo_nxt = tmo_cnt + TW'(1);
        if (!busy_s) begin
          state_nxt = ST_SETUP;
        end else if (tmo_cnt == TMO_LAST) begin
          state_nxt = ST_IDLE;
          tmo_set   = 1'b1;
        end
      end
      ST_SETUP: begin
        if (phase_cnt == '0) begin
          state_nxt = ST_STROBE;
          phase_nxt = STROBE_LD;
        end else begin
          phase_nxt = phase_cnt - PHW'(1);
        end
      end
      ST_STROBE: begin
        if (phase_cnt == '0) begin
          state_nxt = ST_HOLD;
          phase_nxt = HOLD_LD;
        end else begin
          phase_nxt = phase_cnt - PHW'(1);
        end
      end
      ST_HOLD: begin
        if (phase_cnt == '0) begin
          state_nxt = ST_WAIT_ACK;
          tmo_nxt   = '0;
        end else begin
          phase_nxt = phase_cnt - PHW'(1);
        end
      end
      ST_WAIT_ACK: begin
        tmo_nxt = tmo_cnt + TW'(1);
        if (ack_fall) begin
          state_nxt = ST_IDLE;
        end else if (tmo_cnt == TMO_LAST) begin
          state_nxt = ST_IDLE;
          tmo_set   = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      phase_cnt <= '0;
      tmo_cnt   <= '0;
    end else begin
      state     <= state_nxt;
      phase_cnt <= phase_nxt;
      tmo_cnt   <= tmo_nxt;
    end
  end

  // FIFO storage needs no reset: pointers and count define what is valid
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count_nxt;
    end
  end

  // Registered outputs track next-state values so they align with the flops
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data        <= 8'hFF;
      STROBE      <= 1'b1;
      fifo_full   <= 1'b0;
      fifo_empty  <= 1'b1;
      seq_busy    <= 1'b0;
      timeout_err <= 1'b0;
      ovf_err     <= 1'b0;
    end else begin
      if (pop) data <= mem[rd_ptr];
      STROBE     <= (state_nxt != ST_STROBE);
      fifo_full  <= (count_nxt == CW'(DEPTH));
      fifo_empty <= (count_nxt == '0);
      seq_busy   <= (state_nxt != ST_IDLE) || (count_nxt != '0);
      if (tmo_set)      timeout_err <= 1'b1;
      else if (clr_err) timeout_err <= 1'b0;
      if (ovf_set)      ovf_err <= 1'b1;
      else if (clr_err) ovf_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lpt_centronics_sequencer.sv
// Directed bench for lpt_centronics_sequencer: basic byte, FIFO overflow,
// wait timeout, error clear priority and reset during the strobe phase.
module tb_lpt_centronics_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       clr_err;
  logic       BUSY;
  logic       ACK;
  logic [7:0] data;
  logic       STROBE;
  logic       fifo_full;
  logic       fifo_empty;
  logic       seq_busy;
  logic       timeout_err;
  logic       ovf_err;

  int n_vec = 0;
  int n_err = 0;

  lpt_centronics_sequencer #(
    .SETUP_CYC  (4),
    .STROBE_CYC (4),
    .HOLD_CYC   (4),
    .TIMEOUT_CYC(16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .clr_err    (clr_err),
    .BUSY       (BUSY),
    .ACK        (ACK),
    .data       (data),
    .STROBE     (STROBE),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty),
    .seq_busy   (seq_busy),
    .timeout_err(timeout_err),
    .ovf_err    (ovf_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    tick();
    wr_en   = 1'b0;
  endtask

  // Waits (bounded) for one strobe, checks its byte and width, then ACKs it
  task automatic print_byte(input logic [7:0] exp);
    int n;
    int low;
    n = 0;
    while (STROBE === 1'b1 && n < 100) begin
      tick();
      n++;
    end
    check("strobe_seen", 8'(STROBE), 8'h00);
    check("strobe_data", data, exp);
    low = 0;
    while (STROBE === 1'b0 && low < 20) begin
      tick();
      low++;
    end
    check("strobe_width", 8'(low), 8'd4);
    repeat (4) tick();
    ACK = 1'b0;
    repeat (3) tick();
    ACK = 1'b1;
    check("data_after_ack", data, exp);
    repeat (2) tick();
  endtask

  initial begin
    logic strobe_low;
    reset   = 1'b0;
    wr_en   = 1'b0;
    wr_data = 8'h00;
    clr_err = 1'b0;
    BUSY    = 1'b0;
    ACK     = 1'b1;
    repeat (2) tick();

    // reset state
    check("rst_data", data, 8'hFF);
    check("rst_strobe", 8'(STROBE), 8'h01);
    check("rst_empty", 8'(fifo_empty), 8'h01);
    check("rst_full", 8'(fifo_full), 8'h00);
    check("rst_seq_busy", 8'(seq_busy), 8'h00);
    check("rst_tmo_err", 8'(timeout_err), 8'h00);
    check("rst_ovf_err", 8'(ovf_err), 8'h00);
    reset = 1'b1;
    repeat (4) tick();

    // basic byte: push on edge 1, pop on edge 2, strobe low after edges 6..9
    push(8'hA5);
    check("b1_seq_busy", 8'(seq_busy), 8'h01);
    check("b1_empty", 8'(fifo_empty), 8'h00);
    check("b1_data_e1", data, 8'hFF);
    tick();
    check("b1_data_e2", data, 8'hA5);
    check("b1_empty_e2", 8'(fifo_empty), 8'h01);
    check("b1_strobe_e2", 8'(STROBE), 8'h01);
    for (int e = 3; e <= 10; e++) begin
      tick();
      check($sformatf("b1_strobe_e%0d", e), 8'(STROBE), (e >= 6 && e <= 9) ? 8'h00 : 8'h01);
    end
    repeat (4) tick();
    ACK = 1'b0;
    repeat (3) tick();
    ACK = 1'b1;
    check("b1_idle", 8'(seq_busy), 8'h00);
    check("b1_data_hold", data, 8'hA5);
    repeat (2) tick();

    // full FIFO with BUSY high: byte 1 popped, 2..5 stored, 6th rejected
    BUSY = 1'b1;
    repeat (3) tick();
    for (int i = 1; i <= 5; i++) push(8'(i));
    check("f_data_head", data, 8'h01);
    check("f_full", 8'(fifo_full), 8'h01);
    check("f_ovf_none", 8'(ovf_err), 8'h00);
    push(8'h06);
    BUSY = 1'b0;
    check("f_ovf_set", 8'(ovf_err), 8'h01);
    check("f_full_kept", 8'(fifo_full), 8'h01);
    for (int i = 1; i <= 5; i++) print_byte(8'(i));
    check("f_empty_end", 8'(fifo_empty), 8'h01);
    check("f_idle_end", 8'(seq_busy), 8'h00);

    // BUSY timeout: pop on edge 2, error after 16 WAIT_BUSY cycles (edge 18)
    BUSY = 1'b1;
    repeat (3) tick();
    strobe_low = 1'b0;
    push(8'h77);
    repeat (16) begin
      tick();
      if (STROBE !== 1'b1) strobe_low = 1'b1;
    end
    check("t_err_e17", 8'(timeout_err), 8'h00);
    tick();
    if (STROBE !== 1'b1) strobe_low = 1'b1;
    check("t_err_e18", 8'(timeout_err), 8'h01);
    check("t_idle", 8'(seq_busy), 8'h00);
    check("t_strobe_never_low", 8'(strobe_low), 8'h00);
    BUSY = 1'b0;
    repeat (3) tick();
    push(8'h3C);
    print_byte(8'h3C);

    // clr_err alone clears both flags
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("c_tmo_clr", 8'(timeout_err), 8'h00);
    check("c_ovf_clr", 8'(ovf_err), 8'h00);

    // clr_err on the same edge as a new timeout: set wins
    BUSY = 1'b1;
    repeat (3) tick();
    push(8'h5A);
    repeat (16) tick();
    check("c_tmo_before", 8'(timeout_err), 8'h00);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("c_set_wins", 8'(timeout_err), 8'h01);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("c_tmo_clr2", 8'(timeout_err), 8'h00);
    BUSY = 1'b0;
    repeat (3) tick();

    // reset asserted mid-strobe with a byte still queued
    push(8'h99);
    push(8'h42);
    begin
      int n;
      n = 0;
      while (STROBE === 1'b1 && n < 100) begin
        tick();
        n++;
      end
    end
    check("r_strobe_low", 8'(STROBE), 8'h00);
    #2 reset = 1'b0;
    #1;
    check("r_strobe_async", 8'(STROBE), 8'h01);
    check("r_data_async", data, 8'hFF);
    tick();
    reset = 1'b1;
    repeat (3) tick();
    check("r_empty", 8'(fifo_empty), 8'h01);
    check("r_data", data, 8'hFF);
    check("r_seq_busy", 8'(seq_busy), 8'h00);
    check("r_strobe", 8'(STROBE), 8'h01);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
